// File: rtl/ast_pkg.sv
// Shared definitions for the Avalon-ST source and its monitors: the legal
// ready-latency range and the position of a beat inside a packet.
package ast_pkg;

   localparam int RL_MIN = 0;
   localparam int RL_MAX = 8;

   typedef enum logic [1:0] {
      FIRST,
      MIDDLE,
      LAST
   } pkt_pos_e;

   // Position of beat number 'beat' (0-based) in a packet of 'pkt_beats' beats.
   // A one-beat packet reports FIRST; callers treat it as LAST as well.
   function automatic pkt_pos_e pkt_pos(input int beat, input int pkt_beats);
      if (beat == 0)                  return FIRST;
      else if (beat == pkt_beats - 1) return LAST;
      else                            return MIDDLE;
   endfunction

endpackage

// File: rtl/ast_skid_buf.sv
// Two-entry buffer for the zero-ready-latency path. Words popped from the FIFO
// land here and are presented to the sink until accepted.
module ast_skid_buf
   import ast_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       occ_o
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       occ;

   // Pointers and occupancy; a simultaneous push and pop leaves occ unchanged.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_i) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push_i) wr_ptr <= ~wr_ptr;
         if (pop_i)  rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; an entry is only observable once occ says it was written.
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr] <= data_i;
   end

   assign valid_o = (occ != 2'd0);
   assign data_o  = valid_o ? mem[rd_ptr] : '0;
   assign occ_o   = occ;

endmodule

// File: rtl/ast_fifo_source.sv
// Avalon-ST source draining a FIFO read port. With a non-zero ready latency it
// pops only on delayed-ready credit so every valid beat is a guaranteed
// transfer; with zero latency it runs through a two-entry skid buffer.
// Packets are framed with SOP/EOP over a fixed number of beats.
module ast_fifo_source
   import ast_pkg::*;
#(
   parameter int DATABITS_PER_SYMBOL = 8,
   parameter int SYMBOLS_PER_BEAT    = 4,
   parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
   parameter int READY_LATENCY       = 2,
   parameter int READY_ALLOWANCE     = 3,
   parameter int PKT_BEATS           = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] fifo_data_i,
   input  logic             fifo_empty_i,
   output logic             fifo_rd_o,
   input  logic             src_ready_i,
   output logic             src_valid_o,
   output logic [WIDTH-1:0] src_data_o,
   output logic             src_sop_o,
   output logic             src_eop_o
);

   localparam int              CNT_W    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_BEATS - 1);

   logic             xfer;
   logic             valid;
   logic [CNT_W-1:0] beat_cnt;
   pkt_pos_e         pos;

   if (READY_LATENCY < RL_MIN || READY_LATENCY > RL_MAX ||
       READY_ALLOWANCE < READY_LATENCY || PKT_BEATS < 1) begin : g_bad_params
      $error("ast_fifo_source: illegal READY_LATENCY/READY_ALLOWANCE/PKT_BEATS");
   end

   if (READY_LATENCY == 0) begin : g_skid
      logic       pop_q;
      logic [1:0] occ;
      logic [2:0] fill;

      // A word popped this cycle arrives from the FIFO next cycle.
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) pop_q <= 1'b0;
         else        pop_q <= fifo_rd_o;
      end

      // Pop only if the word will still fit after in-flight arrival and this transfer.
      assign xfer      = valid & src_ready_i;
      assign fill      = {1'b0, occ} + {2'b0, pop_q} - {2'b0, xfer};
      assign fifo_rd_o = rst_i & ~fifo_empty_i & (fill < 3'd2);

      ast_skid_buf #(
         .WIDTH (WIDTH)
      ) u_skid (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (pop_q),
         .data_i  (fifo_data_i),
         .pop_i   (xfer),
         .valid_o (valid),
         .data_o  (src_data_o),
         .occ_o   (occ)
      );
   end else begin : g_credit
      logic tap;
      logic pop_q;

      if (READY_LATENCY == 1) begin : g_direct
         assign tap = src_ready_i;
      end else begin : g_hist
         logic [READY_LATENCY-2:0] ready_hist;

         // Delay line of ready so the pop lines up with the sink's acceptance slot.
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               ready_hist <= '0;
            end else begin
               ready_hist[0] <= src_ready_i;
               for (int i = 1; i < READY_LATENCY - 1; i++) ready_hist[i] <= ready_hist[i-1];
            end
         end

         assign tap = ready_hist[READY_LATENCY-2];
      end

      assign fifo_rd_o = rst_i & tap & ~fifo_empty_i;

      // The popped word is on fifo_data_i one cycle later, exactly in its credited slot.
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) pop_q <= 1'b0;
         else        pop_q <= fifo_rd_o;
      end

      assign valid      = pop_q;
      assign xfer       = pop_q;
      assign src_data_o = pop_q ? fifo_data_i : '0;
   end

   // Packet beat counter, advancing on accepted beats only.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                    beat_cnt <= '0;
      else if (xfer && beat_cnt == CNT_LAST) beat_cnt <= '0;
      else if (xfer)                 beat_cnt <= beat_cnt + 1'b1;
   end

   assign pos         = pkt_pos(int'(beat_cnt), PKT_BEATS);
   assign src_valid_o = valid;
   assign src_sop_o   = valid & (pos == FIRST);
   assign src_eop_o   = valid & ((pos == LAST) | (PKT_BEATS == 1));

endmodule

// File: tb/tb_ast_fifo_source.sv
// Bench for ast_fifo_source: five instances (RL=2, RL=0, RL=1, RL=3, and RL=0
// with one-beat packets), each fed by a registered-read FIFO model.
module tb_ast_fifo_source;
   import ast_pkg::*;

   localparam int N = 5;
   localparam logic [11:0] PAT = 12'b0111_0010_1101;   // bit n = ready in cycle n

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ready [N];
   logic        rd    [N];
   logic        valid [N];
   logic        sop   [N];
   logic        eop   [N];
   logic        empty [N];
   logic [31:0] dat   [N];
   logic [31:0] fdata [N] = '{default: 32'h0};
   logic [31:0] mem   [N][32];
   int          head  [N] = '{default: 0};
   int          tail  [N] = '{default: 0};
   int          checks   = 0;
   int          failures = 0;

   always #5 clk_i = ~clk_i;

   ast_fifo_source #(.READY_LATENCY(2), .PKT_BEATS(4)) u_rl2 (
      .clk_i(clk_i), .rst_i(rst_i), .fifo_data_i(fdata[0]), .fifo_empty_i(empty[0]),
      .fifo_rd_o(rd[0]), .src_ready_i(ready[0]), .src_valid_o(valid[0]),
      .src_data_o(dat[0]), .src_sop_o(sop[0]), .src_eop_o(eop[0]));

   ast_fifo_source #(.READY_LATENCY(0), .PKT_BEATS(4)) u_rl0 (
      .clk_i(clk_i), .rst_i(rst_i), .fifo_data_i(fdata[1]), .fifo_empty_i(empty[1]),
      .fifo_rd_o(rd[1]), .src_ready_i(ready[1]), .src_valid_o(valid[1]),
      .src_data_o(dat[1]), .src_sop_o(sop[1]), .src_eop_o(eop[1]));

   ast_fifo_source #(.READY_LATENCY(1), .PKT_BEATS(4)) u_rl1 (
      .clk_i(clk_i), .rst_i(rst_i), .fifo_data_i(fdata[2]), .fifo_empty_i(empty[2]),
      .fifo_rd_o(rd[2]), .src_ready_i(ready[2]), .src_valid_o(valid[2]),
      .src_data_o(dat[2]), .src_sop_o(sop[2]), .src_eop_o(eop[2]));

   ast_fifo_source #(.READY_LATENCY(3), .PKT_BEATS(4)) u_rl3 (
      .clk_i(clk_i), .rst_i(rst_i), .fifo_data_i(fdata[3]), .fifo_empty_i(empty[3]),
      .fifo_rd_o(rd[3]), .src_ready_i(ready[3]), .src_valid_o(valid[3]),
      .src_data_o(dat[3]), .src_sop_o(sop[3]), .src_eop_o(eop[3]));

   ast_fifo_source #(.READY_LATENCY(0), .PKT_BEATS(1)) u_p1 (
      .clk_i(clk_i), .rst_i(rst_i), .fifo_data_i(fdata[4]), .fifo_empty_i(empty[4]),
      .fifo_rd_o(rd[4]), .src_ready_i(ready[4]), .src_valid_o(valid[4]),
      .src_data_o(dat[4]), .src_sop_o(sop[4]), .src_eop_o(eop[4]));

   // FIFO models: empty flag from pointers.
   always_comb begin
      for (int k = 0; k < N; k++) empty[k] = (head[k] == tail[k]);
   end

   // FIFO models: registered read data, valid the cycle after the pop.
   always @(posedge clk_i) begin
      for (int k = 0; k < N; k++) begin
         if (rd[k] && !empty[k]) begin
            fdata[k] <= mem[k][head[k] % 32];
            head[k]  <= head[k] + 1;
         end
      end
   end

   task automatic push(input int k, input logic [31:0] v);
      mem[k][tail[k] % 32] = v;
      tail[k] = tail[k] + 1;
   endtask

   function automatic logic [35:0] obs(input int k);
      return {rd[k], valid[k], sop[k], eop[k], dat[k]};
   endfunction

   function automatic logic [35:0] mk(input logic r, input logic v, input logic s,
                                      input logic e, input logic [31:0] d);
      return {r, v, s, e, d};
   endfunction

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 4; n++) begin
         @(posedge clk_i); #1;
         if (n == 2) rst_i = 1'b1;
         @(negedge clk_i);
         for (int k = 0; k < N; k++) begin
            checks++;
            if (obs(k) !== 36'h0) begin
               failures++;
               $display("FAIL reset inst=%0d n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                        k, n, obs(k), 36'h0);
            end
         end
      end
   endtask

   // RL=2, eight preloaded words, ready held high.
   task automatic test_back_to_back();
      logic [35:0] exp;
      logic        ev;
      @(posedge clk_i); #1;
      for (int i = 1; i <= 8; i++) push(0, 32'(i));
      for (int n = 0; n < 12; n++) begin
         @(posedge clk_i); #1;
         ready[0] = 1'b1;
         @(negedge clk_i);
         ev  = (n >= 2 && n <= 9);
         exp = mk(n >= 1 && n <= 8, ev, ev && ((n - 2) % 4 == 0), ev && ((n - 2) % 4 == 3),
                  ev ? 32'(n - 1) : 32'h0);
         checks++;
         if (obs(0) !== exp) begin
            failures++;
            $display("FAIL back_to_back n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(0), exp);
         end
      end
      ready[0] = 1'b0;
      idle(3);
   endtask

   // RL=2, irregular ready: a beat exactly two cycles after each ready=1.
   task automatic test_ready_pattern();
      logic [35:0] exp;
      logic        er, ev;
      pkt_pos_e    p;
      int          beats = 0;
      for (int i = 0; i < 8; i++) push(0, 32'h11 + 32'(i));
      for (int n = 0; n < 14; n++) begin
         @(posedge clk_i); #1;
         ready[0] = (n < 12) ? PAT[n] : 1'b0;
         @(negedge clk_i);
         er = (n >= 1 && n <= 12) ? PAT[n-1] : 1'b0;
         ev = (n >= 2)            ? PAT[n-2] : 1'b0;
         if (ev) begin
            p     = pkt_pos(beats % 4, 4);
            exp   = mk(er, 1'b1, p == FIRST, p == LAST, 32'h11 + 32'(beats));
            beats = beats + 1;
         end else begin
            exp = mk(er, 1'b0, 1'b0, 1'b0, 32'h0);
         end
         checks++;
         if (obs(0) !== exp) begin
            failures++;
            $display("FAIL ready_pattern n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(0), exp);
         end
      end
      idle(3);
   endtask

   // RL=0, six words, sink stalls for three cycles mid-stream.
   task automatic test_skid_stall();
      logic [35:0] tbl [12];
      logic [11:0] rdy = 12'b1111_1100_0111;
      tbl = '{mk(1,0,0,0,32'h0),  mk(1,0,0,0,32'h0),  mk(1,1,1,0,32'hA0), mk(0,1,0,0,32'hA1),
              mk(0,1,0,0,32'hA1), mk(0,1,0,0,32'hA1), mk(1,1,0,0,32'hA1), mk(1,1,0,0,32'hA2),
              mk(1,1,0,1,32'hA3), mk(0,1,1,0,32'hA4), mk(0,1,0,0,32'hA5), mk(0,0,0,0,32'h0)};
      for (int n = 0; n < 12; n++) begin
         @(posedge clk_i); #1;
         if (n == 0) for (int i = 0; i < 6; i++) push(1, 32'hA0 + 32'(i));
         ready[1] = rdy[n];
         @(negedge clk_i);
         checks++;
         if (obs(1) !== tbl[n]) begin
            failures++;
            $display("FAIL skid_stall n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(1), tbl[n]);
         end
      end
      ready[1] = 1'b0;
      idle(3);
   endtask

   // RL=1, FIFO runs dry after beat 2 and refills five cycles later.
   task automatic test_empty_mid_packet();
      logic [35:0] tbl [11];
      tbl = '{mk(1,0,0,0,32'h0),  mk(1,1,1,0,32'hB1), mk(0,1,0,0,32'hB2), mk(0,0,0,0,32'h0),
              mk(0,0,0,0,32'h0),  mk(0,0,0,0,32'h0),  mk(0,0,0,0,32'h0),  mk(1,0,0,0,32'h0),
              mk(1,1,0,0,32'hB3), mk(0,1,0,1,32'hB4), mk(0,0,0,0,32'h0)};
      for (int n = 0; n < 11; n++) begin
         @(posedge clk_i); #1;
         ready[2] = 1'b1;
         if (n == 0) begin push(2, 32'hB1); push(2, 32'hB2); end
         if (n == 7) begin push(2, 32'hB3); push(2, 32'hB4); end
         @(negedge clk_i);
         checks++;
         if (obs(2) !== tbl[n]) begin
            failures++;
            $display("FAIL empty_mid_packet n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(2), tbl[n]);
         end
      end
      ready[2] = 1'b0;
      idle(3);
   endtask

   // RL=3, reset pulsed while C2 is in flight; C2 is lost, C3 restarts the packet.
   task automatic test_reset_midflight();
      logic [35:0] tbl [13];
      tbl = '{mk(0,0,0,0,32'h0),  mk(0,0,0,0,32'h0),  mk(1,0,0,0,32'h0),  mk(1,1,1,0,32'hC1),
              mk(0,0,0,0,32'h0),  mk(0,0,0,0,32'h0),  mk(0,0,0,0,32'h0),  mk(1,0,0,0,32'h0),
              mk(1,1,1,0,32'hC3), mk(1,1,0,0,32'hC4), mk(1,1,0,0,32'hC5), mk(0,1,0,1,32'hC6),
              mk(0,0,0,0,32'h0)};
      for (int n = 0; n < 13; n++) begin
         @(posedge clk_i); #1;
         ready[3] = 1'b1;
         rst_i    = (n != 4);
         if (n == 0) for (int i = 1; i <= 6; i++) push(3, 32'hC0 + 32'(i));
         @(negedge clk_i);
         checks++;
         if (obs(3) !== tbl[n]) begin
            failures++;
            $display("FAIL reset_midflight n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(3), tbl[n]);
         end
      end
      ready[3] = 1'b0;
      idle(3);
   endtask

   // RL=0 with one-beat packets: SOP and EOP on every beat.
   task automatic test_single_beat();
      logic [35:0] tbl [6];
      tbl = '{mk(1,0,0,0,32'h0),  mk(1,0,0,0,32'h0),  mk(1,1,1,1,32'hD1),
              mk(0,1,1,1,32'hD2), mk(0,1,1,1,32'hD3), mk(0,0,0,0,32'h0)};
      for (int n = 0; n < 6; n++) begin
         @(posedge clk_i); #1;
         ready[4] = 1'b1;
         if (n == 0) for (int i = 1; i <= 3; i++) push(4, 32'hD0 + 32'(i));
         @(negedge clk_i);
         checks++;
         if (obs(4) !== tbl[n]) begin
            failures++;
            $display("FAIL single_beat n=%0d {rd,v,sop,eop,data} got=%09h exp=%09h",
                     n, obs(4), tbl[n]);
         end
      end
      ready[4] = 1'b0;
      idle(2);
   endtask

   initial begin
      rst_i = 1'b0;
      for (int k = 0; k < N; k++) ready[k] = 1'b0;
      test_reset();
      test_back_to_back();
      test_ready_pattern();
      test_skid_stall();
      test_empty_mid_packet();
      test_reset_midflight();
      test_single_beat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
